// File: rtl/cadr_pkg.sv
// Shared definitions for the microcode fetch-source sequencer: state encoding,
// PROM geometry and the bottom-1k region test.
package cadr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DEBUG = 2'd2
  } state_t;

  localparam int PC_BITS          = 14;
  localparam int PROM_WORDS       = 512;
  localparam int PROM_ADDR_BITS   = $clog2(PROM_WORDS);
  localparam int PROM_REGION_BITS = 10;

  // PROM only shadows the bottom 1k of microcode space.
  function automatic logic in_prom_region(input logic [PC_BITS-1:0] pc);
    return pc[PC_BITS-1:PROM_REGION_BITS] == '0;
  endfunction

endpackage

// File: rtl/prom_iram_seq_if.sv
// Fetch-path bundle between the microcode sequencer/debug side (master)
// and the fetch-source sequencer (slave).
interface prom_iram_seq_if;
  import cadr_pkg::*;

  // fetch/pc/iwrite are sampled in the cycle fetch is high; no ready exists,
  // the sequencer must instead hold pc while stall is high. dbg_req is a level
  // request, answered by the idebug level plus a one-cycle dbg_ack on entry.
  logic                      fetch;
  logic [PC_BITS-1:0]        pc;
  logic                      iwrite;
  logic                      dbg_req;
  logic                      promdis_wr;
  logic                      promdis_data;
  logic                      promenable;
  logic [PROM_ADDR_BITS-1:0] promaddr;
  logic                      prom_valid;
  logic                      promdisabled;
  logic                      idebug;
  logic                      dbg_ack;
  logic                      iwrited;
  logic                      iram_we;
  logic                      stall;

  modport master (
    output fetch, pc, iwrite, dbg_req, promdis_wr, promdis_data,
    input  promenable, promaddr, prom_valid, promdisabled,
           idebug, dbg_ack, iwrited, iram_we, stall
  );

  modport slave (
    input  fetch, pc, iwrite, dbg_req, promdis_wr, promdis_data,
    output promenable, promaddr, prom_valid, promdisabled,
           idebug, dbg_ack, iwrited, iram_we, stall
  );

endinterface

// File: rtl/prom_valid_pipe.sv
// PROM read-valid delay line: the enable reappears PROM_LAT cycles later;
// synchronous flush drops anything in flight.
module prom_valid_pipe #(
  parameter int PROM_LAT = 1
) (
  input  logic clk,
  input  logic flush,
  input  logic in_valid,
  output logic out_valid
);

  logic [PROM_LAT-1:0] sr;

  always_ff @(posedge clk) begin
    if (flush) begin
      sr <= '0;
    end else begin
      sr[0] <= in_valid;
      for (int i = 1; i < PROM_LAT; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign out_valid = sr[PROM_LAT-1];

endmodule

// File: rtl/prom_iram_seq.sv
// Chooses the instruction source per fetch (boot PROM, IRAM, debug-forced IR),
// runs the multi-cycle IRAM write and holds the PROM-disable latch.
module prom_iram_seq
  import cadr_pkg::*;
#(
  parameter int IWR_CYCLES = 2,
  parameter int PROM_LAT   = 1
) (
  input  logic               clk,
  input  logic               reset,
  prom_iram_seq_if.slave     bus,
  output state_t             dbg_state
);

  localparam int CW = (IWR_CYCLES > 2) ? $clog2(IWR_CYCLES) : 1;

  state_t        state, state_nxt, prev_state;
  logic [CW-1:0] wr_cnt;
  logic          wr_from_dbg;
  logic          promdisabled_q;
  logic          wr_start;

  assign wr_start  = (state != ST_WRITE) && (state_nxt == ST_WRITE);
  assign dbg_state = state;

  // State register, write counter and where the write was launched from.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      prev_state  <= ST_IDLE;
      wr_cnt      <= '0;
      wr_from_dbg <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev_state <= state;
      if (wr_start) begin
        wr_cnt      <= CW'(IWR_CYCLES - 1);
        wr_from_dbg <= (state == ST_DEBUG);
      end else if (state == ST_WRITE && wr_cnt != '0) begin
        wr_cnt <= wr_cnt - CW'(1);
      end
    end
  end

  // A write launched from DEBUG resumes DEBUG directly; one from IDLE goes
  // back through IDLE so a pending dbg_req is seen one cycle later.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.fetch && bus.iwrite) state_nxt = ST_WRITE;
        else if (bus.dbg_req)        state_nxt = ST_DEBUG;
      end
      ST_WRITE: begin
        if (wr_cnt == '0)
          state_nxt = (wr_from_dbg && bus.dbg_req) ? ST_DEBUG : ST_IDLE;
      end
      ST_DEBUG: begin
        if (bus.fetch && bus.iwrite) state_nxt = ST_WRITE;
        else if (!bus.dbg_req)       state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.iwrited    = (state == ST_WRITE);
    bus.stall      = (state == ST_WRITE);
    bus.iram_we    = (state == ST_WRITE) && (wr_cnt == '0);
    bus.idebug     = (state == ST_DEBUG);
    bus.dbg_ack    = (state == ST_DEBUG) && (prev_state == ST_IDLE);
    bus.promenable = bus.fetch && in_prom_region(bus.pc) && !promdisabled_q
                     && (state == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset)               promdisabled_q <= 1'b0;
    else if (bus.promdis_wr) promdisabled_q <= bus.promdis_data;
  end

  assign bus.promdisabled = promdisabled_q;
  assign bus.promaddr     = bus.pc[PROM_ADDR_BITS-1:0];

  prom_valid_pipe #(.PROM_LAT(PROM_LAT)) u_valid_pipe (
    .clk       (clk),
    .flush     (reset),
    .in_valid  (bus.promenable),
    .out_valid (bus.prom_valid)
  );

endmodule

// File: tb/tb_prom_iram_seq.sv
// Bench for prom_iram_seq: directed scenarios then random traffic, every
// output compared each cycle against a behavioural model.
module tb_prom_iram_seq;
  import cadr_pkg::*;

  localparam int IWR_CYCLES = 2;
  localparam int PROM_LAT   = 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  prom_iram_seq_if bus_if();
  state_t          dbg_state;

  prom_iram_seq #(.IWR_CYCLES(IWR_CYCLES), .PROM_LAT(PROM_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if.slave),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: remaining write cycles, debug mode, latch, valid queue
  int   m_wr_left  = 0;
  bit   m_debug    = 1'b0;
  bit   m_from_dbg = 1'b0;
  bit   m_ack      = 1'b0;
  bit   m_promdis  = 1'b0;
  bit   m_known    = 1'b0;
  logic exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step(input bit rst, input bit f, input logic [13:0] p,
                      input bit iw, input bit dr, input bit pw, input bit pd);
    bit writing;
    bit exp_pe;
    bit new_ack;
    int exp_st;
    @(negedge clk);
    reset               = rst;
    bus_if.fetch        = f;
    bus_if.pc           = p;
    bus_if.iwrite       = iw;
    bus_if.dbg_req      = dr;
    bus_if.promdis_wr   = pw;
    bus_if.promdis_data = pd;
    #1;
    writing = (m_wr_left > 0);
    exp_pe  = f && (int'(p) < 1024) && !m_promdis && !m_debug && !writing;
    exp_st  = writing ? 1 : (m_debug ? 2 : 0);
    if (m_known) begin
      check("promenable",   32'(bus_if.promenable),   32'(exp_pe));
      check("promaddr",     32'(bus_if.promaddr),     32'(int'(p) % 512));
      check("prom_valid",   32'(bus_if.prom_valid),   32'(exp_q[0]));
      check("promdisabled", 32'(bus_if.promdisabled), 32'(m_promdis));
      check("idebug",       32'(bus_if.idebug),       32'(m_debug));
      check("dbg_ack",      32'(bus_if.dbg_ack),      32'(m_ack));
      check("iwrited",      32'(bus_if.iwrited),      32'(writing));
      check("stall",        32'(bus_if.stall),        32'(writing));
      check("iram_we",      32'(bus_if.iram_we),      32'(writing && m_wr_left == 1));
      check("state",        32'(dbg_state),           32'(exp_st));
    end
    @(posedge clk);
    new_ack = 1'b0;
    if (rst) begin
      m_known = 1'b1; m_wr_left = 0; m_debug = 1'b0; m_from_dbg = 1'b0; m_promdis = 1'b0;
      exp_q.delete();
      for (int i = 0; i < PROM_LAT; i++) exp_q.push_back(1'b0);
    end else if (m_known) begin
      void'(exp_q.pop_front());
      exp_q.push_back(exp_pe);
      if (pw) m_promdis = pd;
      if (writing) begin
        m_wr_left--;
        if (m_wr_left == 0) m_debug = m_from_dbg && dr;
      end else if (f && iw) begin
        m_wr_left  = IWR_CYCLES;
        m_from_dbg = m_debug;
        m_debug    = 1'b0;
      end else if (m_debug) begin
        m_debug = dr;
      end else if (dr) begin
        m_debug = 1'b1;
        new_ack = 1'b1;
      end
    end
    m_ack = new_ack;
  endtask

  task automatic idle(input int n, input bit dr);
    for (int i = 0; i < n; i++) step(0, 0, 14'h0, 0, dr, 0, 0);
  endtask

  initial begin
    bit          dr;
    bit          f;
    bit          iw;
    logic [13:0] p;
    // reset and boot fetches around the 1k boundary
    step(1, 0, 14'h0, 0, 0, 0, 0);
    step(1, 0, 14'h0, 0, 0, 0, 0);
    check("reset_promdisabled", 32'(bus_if.promdisabled), 32'd0);
    step(0, 1, 14'h005, 0, 0, 0, 0);
    step(0, 1, 14'h400, 0, 0, 0, 0);
    step(0, 1, 14'h3ff, 0, 0, 0, 0);
    step(0, 1, 14'h3a55, 0, 0, 0, 0);
    idle(2, 0);
    // PROM disable, then reset re-enables it
    step(0, 0, 14'h0, 0, 0, 1, 1);
    step(0, 1, 14'h010, 0, 0, 0, 0);
    step(1, 0, 14'h0, 0, 0, 0, 0);
    step(0, 1, 14'h010, 0, 0, 0, 0);
    idle(1, 0);
    // IRAM write from IDLE
    step(0, 1, 14'h123, 1, 0, 0, 0);
    step(0, 1, 14'h124, 0, 0, 0, 0);
    idle(3, 0);
    // iwrite beats dbg_req, then debug entry and exit
    step(0, 1, 14'h123, 1, 1, 0, 0);
    idle(5, 1);
    idle(3, 0);
    // reset in the first write cycle
    step(0, 1, 14'h200, 1, 0, 0, 0);
    step(1, 0, 14'h0, 0, 0, 0, 0);
    idle(3, 0);
    // write while in debug, promdis write while in debug
    idle(3, 1);
    step(0, 1, 14'h0ab, 1, 1, 0, 0);
    idle(2, 1);
    step(0, 1, 14'h050, 0, 1, 1, 1);
    step(0, 1, 14'h050, 0, 1, 1, 0);
    idle(2, 0);
    step(0, 1, 14'h050, 0, 0, 0, 0);
    // random traffic
    dr = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) dr = ~dr;
      f  = ($urandom_range(0, 3) != 0);
      iw = ($urandom_range(0, 7) == 0);
      p  = ($urandom_range(0, 3) == 0) ? 14'($urandom) : 14'($urandom_range(0, 1023));
      step(($urandom_range(0, 79) == 0), f, p, iw, dr,
           ($urandom_range(0, 15) == 0), 1'($urandom));
    end
    idle(2, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prom_iram_seq.md
Name: prom_iram_seq

Overview:
- Sequences the instruction source for the microcode fetch path. Selects between boot PROM, IRAM and the debug-forced IR for each fetch.
- Owns the `promdisabled` latch, the `idebug` handshake with the debug interface, and the multi-cycle IRAM write sequence (`iwrited`, `iram_we`).
- Produces the PROM enable/address consumed by the PROM block and the fetch-stall signal consumed by the sequencer.

Parameters:
- IWR_CYCLES, 2, cycles `iwrited` stays asserted per IRAM write (≥2); `iram_we` fires in the last one.
- PROM_LAT, 1, PROM read latency in cycles from `promenable` to `prom_valid` (1..3).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fetch  in  1  fetch strobe: a new pc is presented this cycle
- pc  in  14  microcode pc for the fetch
- iwrite  in  1  request to write IRAM at `pc` (sampled with `fetch`)
- dbg_req  in  1  debug interface requests forced-IR mode (level)
- promdis_wr  in  1  bus write to PROM-disable register
- promdis_data  in  1  value written (1 = disable PROM)
- promenable  out  1  PROM selected for this fetch
- promaddr  out  9  PROM word address, equal to `pc[8:0]`
- prom_valid  out  1  PROM data valid, PROM_LAT cycles after `promenable`
- promdisabled  out  1  PROM-disable latch
- idebug  out  1  forced-IR mode active
- dbg_ack  out  1  one-cycle pulse on entry to DEBUG
- iwrited  out  1  IRAM write sequence in progress
- iram_we  out  1  IRAM write-enable pulse
- stall  out  1  sequencer must hold pc

Behaviour:
- Reset values: all outputs 0; state IDLE; write counter 0; PROM valid pipe cleared. `promdisabled` is 0 after reset, so the machine boots from PROM.
- `promdisabled`: loaded from `promdis_data` on `promdis_wr`; otherwise holds. A write takes effect on the next cycle.
- bottom_1k = `pc[13:10]` == 0.
- `promenable` (combinational) = `fetch` & bottom_1k & ~`promdisabled` & ~`idebug` & ~`iwrited`.
- `promaddr` = `pc[8:0]` at all times.
- `prom_valid` is `promenable` delayed by PROM_LAT registers. The pipe is flushed on reset.

State machine states: IDLE, WRITE, DEBUG.
- IDLE:
  - `fetch` & `iwrite` → WRITE; load counter with IWR_CYCLES-1.
  - Otherwise `dbg_req` → DEBUG; pulse `dbg_ack` in the first DEBUG cycle.
  - `iwrite` has priority over `dbg_req` in the same cycle.
- WRITE:
  - `iwrited`=1 and `stall`=1 for exactly IWR_CYCLES cycles.
  - `iram_we`=1 only in the cycle where the counter is 0; then → IDLE.
  - `dbg_req` is ignored until return to IDLE, then honoured on the next cycle.
  - `fetch` during WRITE is ignored; `stall` covers it.
- DEBUG:
  - `idebug`=1, `stall`=0.
  - Stay while `dbg_req`=1; when `dbg_req` falls → IDLE; `idebug` drops the following cycle.
  - `iwrite` with `fetch` in DEBUG → WRITE (debug may load IRAM). `idebug` deasserts during WRITE, and the block returns to DEBUG afterwards if `dbg_req` is still high.
- `stall` = state==WRITE.
- `pc` ≥ 1024 or PROM disabled: `promenable`=0, and no `prom_valid` issues for that fetch.
- Reset mid-WRITE: the sequence aborts and `iram_we` must not assert. The IRAM write is lost by design.
- `promdis_wr` during WRITE/DEBUG: accepted immediately, independent of state.

Decomposition:
- Shared package (`cadr_pkg`):
  - state encoding (IDLE=0, WRITE=1, DEBUG=2)
  - PROM_WORDS=512
  - PROM_REGION_BITS=10 (bottom-1k boundary)
- One natural sub-module, `prom_valid_pipe`: a PROM_LAT-deep valid shift register with synchronous flush.
- The FSM, counter and `promdisabled` latch stay in the top module.

Test Plan:
- Boot fetch: reset, then `fetch` with `pc`=0x005 → `promenable`=1, `promaddr`=0x005, `prom_valid`=1 one cycle later (PROM_LAT=1); `pc`=0x400 → `promenable`=0.
- PROM disable: `promdis_wr`=1, `promdis_data`=1 → `promdisabled`=1 next cycle; fetch `pc`=0x010 → `promenable`=0; after reset, `promdisabled`=0.
- IRAM write: `fetch`+`iwrite` at `pc`=0x123 → `iwrited`/`stall` high 2 cycles, `iram_we` only in the 2nd, then IDLE; `promenable` stays 0 throughout.
- Priority: `iwrite`+`fetch`+`dbg_req` same cycle → WRITE first (2 cycles), then DEBUG with a `dbg_ack` pulse; `idebug`=1 until `dbg_req` drops, then 0 one cycle later.
- Reset mid-write: assert `reset` in the 1st WRITE cycle → next cycle all outputs 0, `iram_we` never pulses.
- Write from debug: in DEBUG, `fetch`+`iwrite` → `idebug`=0 for 2 cycles, `iram_we` pulse, back to DEBUG with `idebug`=1 and no second `dbg_ack`.
